// File: rtl/dmem_pkg.sv
// Shared definitions for the dual-port data-memory responder.
// Holds the arbitration state encoding, the default RAM depth and the
// word-index width derived from it, plus a small alignment helper.
package dmem_pkg;

  localparam int DEPTH_LOG2_DEF = 10;
  localparam int IDX_W          = DEPTH_LOG2_DEF;

  typedef enum logic {
    IDLE       = 1'b0,
    PEND_SLAVE = 1'b1
  } arbState_e;

  function automatic logic isMisaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM of 32-bit words.
// Write and read both happen on the rising edge. A read in the same cycle
// as a write returns the old contents. The array has no reset, so
// contents survive a reset of the surrounding logic.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int IDX_W = dmem_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] r_mem [2**IDX_W];
  logic [31:0] r_rdata;

  // Store the write data and register the addressed word on every edge
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    r_rdata <= r_mem[idx];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dual_dmem_resp.sv
// Dual-CPU data-memory responder: the master and slave data pipes share one
// single-port RAM, with one access per cycle. The master wins a tie and the
// slave is served on the following cycle, so neither port waits more than
// one cycle. Misaligned accesses are accepted but have no effect, and they
// raise a sticky per-port error flag.
// Optional build macro: DMEM_PERF_CNT_EN adds the conflict_cnt output, a
// saturating count of the cycles in which both ports request.
module dual_dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        errM,
  input  logic        memenM_slave,
  input  logic        memwriteM_slave,
  input  logic [31:0] aluoutM_slave,
  input  logic [31:0] writedataM_slave,
  output logic [31:0] readdataM_slave,
  output logic        stallM_slave,
  output logic        errM_slave
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] conflict_cnt
`endif
);

  arbState_e r_state;
  arbState_e w_nextState;
  logic      w_accM;
  logic      w_accS;
  logic      w_stallM;
  logic      w_stallS;

  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic                  w_wr;
  logic                  w_mis;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_ramRdata;
  logic                  w_unusedAddrBits;

  logic        r_ldValidM;
  logic        r_ldValidS;
  logic [31:0] r_holdM;
  logic [31:0] r_holdS;
  logic        r_errM;
  logic        r_errS;

  // Arbitration: decide which port owns the RAM this cycle and who stalls.
  // Everything is held off while reset is asserted.
  always_comb begin
    w_accM      = 1'b0;
    w_accS      = 1'b0;
    w_stallM    = 1'b0;
    w_stallS    = 1'b0;
    w_nextState = IDLE;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (memenM) begin
            w_accM = 1'b1;
            if (memenM_slave) begin
              w_stallS    = 1'b1;
              w_nextState = PEND_SLAVE;
            end
          end else if (memenM_slave) begin
            w_accS = 1'b1;
          end
        end
        PEND_SLAVE: begin
          if (memenM_slave) begin
            w_accS   = 1'b1;
            w_stallM = memenM;
          end else begin
            w_accM = memenM;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_addr  = w_accS ? aluoutM_slave    : aluoutM;
  assign w_wdata = w_accS ? writedataM_slave : writedataM;
  assign w_wr    = w_accS ? memwriteM_slave  : memwriteM;
  assign w_mis   = isMisaligned(w_addr);
  assign w_we    = (w_accM | w_accS) & w_wr & ~w_mis;
  assign w_idx   = w_addr[DEPTH_LOG2+1:2];

  // Address bits above the RAM index are ignored so accesses wrap around.
  assign w_unusedAddrBits = ^w_addr[31:DEPTH_LOG2+2];

  dmem_ram #(
    .IDX_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .idx   (w_idx),
    .wdata (w_wdata),
    .rdata (w_ramRdata)
  );

  // Arbitration state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Master read-data tracking and sticky misalignment flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ldValidM <= 1'b0;
      r_holdM    <= '0;
      r_errM     <= 1'b0;
    end else begin
      r_ldValidM <= w_accM & ~w_wr & ~w_mis;
      if (w_accM & ~w_wr & w_mis) begin
        r_holdM <= '0;
      end else if (r_ldValidM) begin
        r_holdM <= w_ramRdata;
      end
      if (w_accM & w_mis) begin
        r_errM <= 1'b1;
      end
    end
  end

  // Slave read-data tracking and sticky misalignment flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ldValidS <= 1'b0;
      r_holdS    <= '0;
      r_errS     <= 1'b0;
    end else begin
      r_ldValidS <= w_accS & ~w_wr & ~w_mis;
      if (w_accS & ~w_wr & w_mis) begin
        r_holdS <= '0;
      end else if (r_ldValidS) begin
        r_holdS <= w_ramRdata;
      end
      if (w_accS & w_mis) begin
        r_errS <= 1'b1;
      end
    end
  end

  assign readdataM       = r_ldValidM ? w_ramRdata : r_holdM;
  assign readdataM_slave = r_ldValidS ? w_ramRdata : r_holdS;
  assign stallM          = w_stallM;
  assign stallM_slave    = w_stallS;
  assign errM            = r_errM;
  assign errM_slave      = r_errS;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] r_conflictCnt;

  // Saturating count of cycles in which both ports request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflictCnt <= '0;
    end else if (memenM & memenM_slave & (r_conflictCnt != 32'hFFFF_FFFF)) begin
      r_conflictCnt <= r_conflictCnt + 32'd1;
    end
  end

  assign conflict_cnt = r_conflictCnt;
`endif

endmodule

// File: tb/tb_dual_dmem_resp.sv
// Self-checking bench for dual_dmem_resp.
// A reference word memory and a tie-break model predict the expected stall,
// error and counter values for every cycle. Each accepted load pushes its
// expected data onto a per-port queue. The entry is popped and compared
// when the read data becomes due on the following cycle.
// Build with DMEM_PERF_CNT_EN defined to also exercise conflict_cnt.
module tb_dual_dmem_resp;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic        clk;
  logic        rst;
  logic        memenM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        errM;
  logic        memenM_slave;
  logic        memwriteM_slave;
  logic [31:0] aluoutM_slave;
  logic [31:0] writedataM_slave;
  logic [31:0] readdataM_slave;
  logic        stallM_slave;
  logic        errM_slave;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] conflict_cnt;
`endif

  int testsRun;
  int testsFailed;

  logic [31:0] model [int];
  logic [31:0] qM [$];
  logic [31:0] qS [$];
  bit          pendM;
  bit          pendS;
  logic [31:0] lastM;
  logic [31:0] lastS;
  bit          modelPend;
  bit          expErrM;
  bit          expErrS;
  logic [31:0] expCnt;
  bit          prevStallM;
  bit          prevStallS;

  dual_dmem_resp dut (
    .clk              (clk),
    .rst              (rst),
    .memenM           (memenM),
    .memwriteM        (memwriteM),
    .aluoutM          (aluoutM),
    .writedataM       (writedataM),
    .readdataM        (readdataM),
    .stallM           (stallM),
    .errM             (errM),
    .memenM_slave     (memenM_slave),
    .memwriteM_slave  (memwriteM_slave),
    .aluoutM_slave    (aluoutM_slave),
    .writedataM_slave (writedataM_slave),
    .readdataM_slave  (readdataM_slave),
    .stallM_slave     (stallM_slave),
    .errM_slave       (errM_slave)
`ifdef DMEM_PERF_CNT_EN
    ,
    .conflict_cnt     (conflict_cnt)
`endif
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count a comparison and report it when the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mkReq(input logic en, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data);
    req_t r;
    r.en   = en;
    r.wr   = wr;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

  // Word index of a byte address for a 1024-word RAM
  function automatic int wordIdx(input logic [31:0] a);
    return int'((a >> 2) & 32'h0000_03FF);
  endfunction

  // Random request into the preloaded 16-word pool, optionally misaligned
  function automatic req_t newReq(input int enPct, input int misPct);
    req_t r;
    r.en   = ($urandom_range(99) < enPct);
    r.wr   = 1'($urandom_range(1));
    r.addr = 32'($urandom_range(15)) << 2;
    if ($urandom_range(99) < misPct) begin
      r.addr[1:0] = 2'($urandom_range(3, 1));
    end
    r.data = $urandom;
    return r;
  endfunction

  task automatic resetModel();
    pendM      = 1'b0;
    pendS      = 1'b0;
    lastM      = '0;
    lastS      = '0;
    modelPend  = 1'b0;
    expErrM    = 1'b0;
    expErrS    = 1'b0;
    expCnt     = '0;
    prevStallM = 1'b0;
    prevStallS = 1'b0;
    qM.delete();
    qS.delete();
  endtask

  // Apply one accepted access to the reference memory and the scoreboard
  task automatic modelAccess(input bit isSlave, input req_t r);
    int idx;
    logic [31:0] val;
    idx = wordIdx(r.addr);
    val = '0;
    if (r.addr[1:0] != 2'b00) begin
      if (isSlave) expErrS = 1'b1;
      else         expErrM = 1'b1;
    end else if (r.wr) begin
      model[idx] = r.data;
    end else begin
      val = model[idx];
    end
    if (!r.wr) begin
      if (isSlave) begin
        qS.push_back(val);
        pendS = 1'b1;
      end else begin
        qM.push_back(val);
        pendM = 1'b1;
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".readdataM"}, readdataM, 32'h0);
    checkOutput({tag, ".readdataS"}, readdataM_slave, 32'h0);
    checkOutput({tag, ".stallM"}, {31'b0, stallM}, 32'h0);
    checkOutput({tag, ".stallS"}, {31'b0, stallM_slave}, 32'h0);
    checkOutput({tag, ".errM"}, {31'b0, errM}, 32'h0);
    checkOutput({tag, ".errS"}, {31'b0, errM_slave}, 32'h0);
`ifdef DMEM_PERF_CNT_EN
    checkOutput({tag, ".cnt"}, conflict_cnt, 32'h0);
`endif
  endtask

  // Drive one cycle of requests, check the outputs at the falling edge and
  // advance the model. Returns which port the model expects to be accepted.
  task automatic applyStimulus(input req_t m, input req_t s, output bit accM, output bit accS);
    bit eStallM;
    bit eStallS;
    memenM           = m.en;
    memwriteM        = m.wr;
    aluoutM          = m.addr;
    writedataM       = m.data;
    memenM_slave     = s.en;
    memwriteM_slave  = s.wr;
    aluoutM_slave    = s.addr;
    writedataM_slave = s.data;
    @(negedge clk);
    if (pendM) lastM = qM.pop_front();
    if (pendS) lastS = qS.pop_front();
    checkOutput("readdataM", readdataM, lastM);
    checkOutput("readdataS", readdataM_slave, lastS);
    checkOutput("errM", {31'b0, errM}, {31'b0, expErrM});
    checkOutput("errS", {31'b0, errM_slave}, {31'b0, expErrS});
`ifdef DMEM_PERF_CNT_EN
    checkOutput("conflictCnt", conflict_cnt, expCnt);
`endif
    eStallS = !modelPend && m.en && s.en;
    eStallM = modelPend && m.en && s.en;
    checkOutput("stallM", {31'b0, stallM}, {31'b0, eStallM});
    checkOutput("stallS", {31'b0, stallM_slave}, {31'b0, eStallS});
    checkOutput("doubleStallM", {31'b0, stallM & prevStallM}, 32'h0);
    checkOutput("doubleStallS", {31'b0, stallM_slave & prevStallS}, 32'h0);
    prevStallM = stallM;
    prevStallS = stallM_slave;
    if (modelPend) begin
      accS = s.en;
      accM = m.en && !s.en;
    end else begin
      accM = m.en;
      accS = s.en && !m.en;
    end
    modelPend = !modelPend && m.en && s.en;
    pendM = 1'b0;
    pendS = 1'b0;
    if (accM) modelAccess(1'b0, m);
    if (accS) modelAccess(1'b1, s);
    if (m.en && s.en && (expCnt != 32'hFFFF_FFFF)) expCnt = expCnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check that the outputs clear at once, hold
  // reset over two edges while the master drives duringM, then release
  task automatic pulseReset(input string tag, input req_t duringM);
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs(tag);
    resetModel();
    memenM           = duringM.en;
    memwriteM        = duringM.wr;
    aluoutM          = duringM.addr;
    writedataM       = duringM.data;
    memenM_slave     = 1'b0;
    memwriteM_slave  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    memenM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Main sequence: reset, directed cases, conflict burst, random traffic
  initial begin
    req_t none;
    req_t rm;
    req_t rs;
    bit   aM;
    bit   aS;
    testsRun    = 0;
    testsFailed = 0;
    none        = mkReq(1'b0, 1'b0, 32'h0, 32'h0);
    resetModel();

    rst              = 1'b0;
    memenM           = 1'b1;
    memwriteM        = 1'b0;
    aluoutM          = 32'h0;
    writedataM       = 32'h0;
    memenM_slave     = 1'b1;
    memwriteM_slave  = 1'b0;
    aluoutM_slave    = 32'h4;
    writedataM_slave = 32'h0;
    #3;
    checkResetOutputs("reset0");
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetOutputs("reset1");
    memenM       = 1'b0;
    memenM_slave = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Store then load the same word from the master
    applyStimulus(mkReq(1, 1, 32'h100, 32'hDEAD_BEEF), none, aM, aS);
    applyStimulus(mkReq(1, 0, 32'h100, 32'h0), none, aM, aS);
    applyStimulus(none, none, aM, aS);
    checkOutput("holdDeadBeef", readdataM, 32'hDEAD_BEEF);

    // Both ports load in the same cycle
    applyStimulus(mkReq(1, 1, 32'h0, 32'h11), none, aM, aS);
    applyStimulus(none, mkReq(1, 1, 32'h4, 32'h22), aM, aS);
    applyStimulus(mkReq(1, 1, 32'h200, 32'h1357_9BDF), none, aM, aS);
    applyStimulus(mkReq(1, 0, 32'h0, 32'h0), mkReq(1, 0, 32'h4, 32'h0), aM, aS);
    applyStimulus(none, mkReq(1, 0, 32'h4, 32'h0), aM, aS);
    checkOutput("conflictRdM", readdataM, 32'h11);
    applyStimulus(none, none, aM, aS);
    checkOutput("conflictRdS", readdataM_slave, 32'h22);

    // Master store and slave load to the same word in one conflict
    applyStimulus(mkReq(1, 1, 32'h8, 32'h55), mkReq(1, 0, 32'h8, 32'h0), aM, aS);
    applyStimulus(none, mkReq(1, 0, 32'h8, 32'h0), aM, aS);
    applyStimulus(none, none, aM, aS);
    checkOutput("sameWordRdS", readdataM_slave, 32'h55);

    // Misaligned master store is dropped and sets the sticky flag
    applyStimulus(mkReq(1, 1, 32'h103, 32'h1234_5678), none, aM, aS);
    applyStimulus(mkReq(1, 0, 32'h100, 32'h0), mkReq(1, 0, 32'h4, 32'h0), aM, aS);
    applyStimulus(none, mkReq(1, 0, 32'h4, 32'h0), aM, aS);
    applyStimulus(none, none, aM, aS);
    checkOutput("misStoreWord", readdataM, 32'hDEAD_BEEF);
    checkOutput("misStickyErrM", {31'b0, errM}, 32'h1);
    checkOutput("misSlaveErrS", {31'b0, errM_slave}, 32'h0);
    applyStimulus(mkReq(1, 0, 32'h101, 32'h0), none, aM, aS);
    applyStimulus(none, none, aM, aS);
    checkOutput("misLoadZero", readdataM, 32'h0);

    // Address wrap-around above the RAM size
    applyStimulus(none, mkReq(1, 1, 32'h1000, 32'hCAFE_F00D), aM, aS);
    applyStimulus(mkReq(1, 0, 32'h0, 32'h0), none, aM, aS);
    applyStimulus(none, none, aM, aS);
    checkOutput("wrapLoad", readdataM, 32'hCAFE_F00D);

    // Preload the random-traffic pool
    for (int i = 0; i < 16; i++) begin
      applyStimulus(mkReq(1, 1, 32'(i) << 2, $urandom), none, aM, aS);
    end

    // Ten cycles with both ports requesting, from a clean counter
    pulseReset("pulse", none);
    rm = newReq(100, 0);
    rs = newReq(100, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(rm, rs, aM, aS);
      if (aM) rm = newReq(100, 0);
      if (aS) rs = newReq(100, 0);
    end
    applyStimulus(none, none, aM, aS);
`ifdef DMEM_PERF_CNT_EN
    checkOutput("conflictCnt10", conflict_cnt, 32'd10);
`endif

    // Reset in the middle of conflict traffic while a store to 0x200 waits
    rm = newReq(100, 0);
    rs = newReq(100, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rm, rs, aM, aS);
      if (aM) rm = newReq(100, 0);
      if (aS) rs = newReq(100, 0);
    end
    memenM       = 1'b1;
    memenM_slave = 1'b1;
    pulseReset("midReset", mkReq(1, 1, 32'h200, 32'hBAD0_BAD0));
    applyStimulus(mkReq(1, 0, 32'h200, 32'h0), none, aM, aS);
    applyStimulus(none, none, aM, aS);
    checkOutput("storeDroppedInReset", readdataM, 32'h1357_9BDF);

    // Random traffic; a stalled port holds its request
    rm = newReq(70, 5);
    rs = newReq(70, 5);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(rm, rs, aM, aS);
      if (aM || !rm.en) rm = newReq(70, 5);
      if (aS || !rs.en) rs = newReq(70, 5);
    end
    applyStimulus(none, none, aM, aS);
    applyStimulus(none, none, aM, aS);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
